// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: one read or write INCR burst at a time
// against a word-addressed array, with SLVERR for out-of-range beats.
module axi_mem_responder #(
   parameter int ID_WIDTH = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h0001_0000,
   parameter int DEPTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_WIDTH-1:0]   arid_s_inf,
   input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
   input  logic [7:0]            arlen_s_inf,
   input  logic [2:0]            arsize_s_inf,
   input  logic [1:0]            arburst_s_inf,
   input  logic                  arvalid_s_inf,
   output logic                  arready_s_inf,
   output logic [ID_WIDTH-1:0]   rid_s_inf,
   output logic [DATA_WIDTH-1:0] rdata_s_inf,
   output logic [1:0]            rresp_s_inf,
   output logic                  rlast_s_inf,
   output logic                  rvalid_s_inf,
   input  logic                  rready_s_inf,
   input  logic [ID_WIDTH-1:0]   awid_s_inf,
   input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
   input  logic [2:0]            awsize_s_inf,
   input  logic [1:0]            awburst_s_inf,
   input  logic [7:0]            awlen_s_inf,
   input  logic                  awvalid_s_inf,
   output logic                  awready_s_inf,
   input  logic [DATA_WIDTH-1:0] wdata_s_inf,
   input  logic                  wlast_s_inf,
   input  logic                  wvalid_s_inf,
   output logic                  wready_s_inf,
   output logic [ID_WIDTH-1:0]   bid_s_inf,
   output logic [1:0]            bresp_s_inf,
   output logic                  bvalid_s_inf,
   input  logic                  bready_s_inf
);

   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

   localparam int IW = $clog2(DEPTH);
   localparam int AX = ADDR_WIDTH + 1;
   localparam logic [AX-1:0] LO = AX'(BASE_ADDR);
   localparam logic [AX-1:0] HI = LO + AX'(16 * DEPTH);

   state_t state, state_n;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // one extra address bit so a burst running past the top never wraps
   logic [AX-1:0]       addr_q;
   logic [7:0]          len_q;
   logic [7:0]          cnt_q;
   logic [ID_WIDTH-1:0] id_q;
   logic                attr_err;
   logic                werr;
   logic                idle_rdy;

   logic          ar_hs, aw_hs, r_beat, w_beat, final_beat;
   logic          ar_bad, aw_bad;
   logic [AX-1:0] rd_addr;
   logic          rd_err, wr_err, wl_err, werr_n;
   logic [IW-1:0] rd_idx, wr_idx;

   assign arready_s_inf = idle_rdy;
   assign awready_s_inf = idle_rdy & ~arvalid_s_inf;

   always_comb begin
      ar_hs      = arvalid_s_inf & arready_s_inf;
      aw_hs      = awvalid_s_inf & awready_s_inf;
      r_beat     = rvalid_s_inf & rready_s_inf;
      w_beat     = wvalid_s_inf & wready_s_inf;
      final_beat = (cnt_q == len_q);
      ar_bad     = (arsize_s_inf != 3'b100) || (arburst_s_inf != 2'b01);
      aw_bad     = (awsize_s_inf != 3'b100) || (awburst_s_inf != 2'b01);
      rd_addr    = ar_hs ? {1'b0, araddr_s_inf} : addr_q + AX'(16);
      rd_err     = (rd_addr < LO) || (rd_addr >= HI)
                   || (ar_hs ? ar_bad : attr_err);
      rd_idx     = IW'((rd_addr - LO) >> 4);
      wr_err     = (addr_q < LO) || (addr_q >= HI) || attr_err;
      wr_idx     = IW'((addr_q - LO) >> 4);
      wl_err     = (wlast_s_inf != final_beat);
      werr_n     = werr | wr_err | wl_err;

      state_n = state;
      unique case (state)
         IDLE: begin
            if (ar_hs)      state_n = RD;
            else if (aw_hs) state_n = WR;
         end
         RD:    if (r_beat && rlast_s_inf)         state_n = IDLE;
         WR:    if (w_beat && final_beat)          state_n = WRESP;
         WRESP: if (bvalid_s_inf && bready_s_inf)  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         idle_rdy     <= 1'b0;
         rvalid_s_inf <= 1'b0;
         rlast_s_inf  <= 1'b0;
         rdata_s_inf  <= '0;
         rresp_s_inf  <= 2'b00;
         rid_s_inf    <= '0;
         wready_s_inf <= 1'b0;
         bvalid_s_inf <= 1'b0;
         bresp_s_inf  <= 2'b00;
         bid_s_inf    <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         id_q         <= '0;
         attr_err     <= 1'b0;
         werr         <= 1'b0;
      end else begin
         state        <= state_n;
         idle_rdy     <= (state_n == IDLE);
         rvalid_s_inf <= (state_n == RD);
         wready_s_inf <= (state_n == WR);
         bvalid_s_inf <= (state_n == WRESP);
         if (ar_hs) begin
            addr_q      <= {1'b0, araddr_s_inf};
            len_q       <= arlen_s_inf;
            id_q        <= arid_s_inf;
            attr_err    <= ar_bad;
            cnt_q       <= '0;
            rid_s_inf   <= arid_s_inf;
            rlast_s_inf <= (arlen_s_inf == 8'd0);
            rdata_s_inf <= rd_err ? '0 : mem[rd_idx];
            rresp_s_inf <= rd_err ? 2'b10 : 2'b00;
         end else if (aw_hs) begin
            addr_q   <= {1'b0, awaddr_s_inf};
            len_q    <= awlen_s_inf;
            id_q     <= awid_s_inf;
            attr_err <= aw_bad;
            cnt_q    <= '0;
            werr     <= aw_bad;
         end else if (r_beat) begin
            if (rlast_s_inf) begin
               rlast_s_inf <= 1'b0;
            end else begin
               addr_q      <= rd_addr;
               cnt_q       <= cnt_q + 8'd1;
               rlast_s_inf <= (cnt_q + 8'd1 == len_q);
               rdata_s_inf <= rd_err ? '0 : mem[rd_idx];
               rresp_s_inf <= rd_err ? 2'b10 : 2'b00;
            end
         end else if (w_beat) begin
            addr_q <= addr_q + AX'(16);
            cnt_q  <= cnt_q + 8'd1;
            werr   <= werr_n;
            if (final_beat) begin
               bid_s_inf   <= id_q;
               bresp_s_inf <= werr_n ? 2'b10 : 2'b00;
            end
         end
      end
   end

   // storage survives reset; erroring beats never touch it
   always_ff @(posedge clk) begin
      if (!rst && w_beat && !wr_err)
         mem[wr_idx] <= wdata_s_inf;
   end

endmodule
